// File: rtl/branch_predictor_bht.sv
// Branch history/target table: combinational next-PC lookup on the fetch side,
// 2-bit saturating counter and target update plus mispredict redirect on the
// resolve side, and saturating branch/mispredict counters for performance debug.
module branch_predictor_bht #(
  parameter int PC_W    = 16,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc_current,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_next_pc,
  input  logic              res_valid,
  input  logic              res_is_branch,
  input  logic [PC_W-1:0]   res_pc,
  input  logic [PC_W-1:0]   res_pc_plus,
  input  logic [PC_W-1:0]   res_target,
  input  logic              res_taken,
  input  logic              res_pred_taken,
  input  logic              tbl_clear,
  output logic              change_pc,
  output logic [PC_W-1:0]   next_pc,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  localparam logic [CTR_W-1:0]  CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  CTR_MIN = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0]  CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};
  localparam logic [CTR_W-1:0]  CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0]  CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [PC_W-1:0]   PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  // Table storage, one element per entry.
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [PC_W-1:0]  target_d [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];
  logic [CTR_W-1:0] ctr_d    [ENTRIES];

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] rs_idx;
  logic [TAG_W-1:0] rs_tag;
  logic             rs_hit;
  logic             res_evt;

  assign lk_idx  = pc_current[IDX_W-1:0];
  assign lk_tag  = pc_current[PC_W-1:IDX_W];
  assign rs_idx  = res_pc[IDX_W-1:0];
  assign rs_tag  = res_pc[PC_W-1:IDX_W];
  assign res_evt = reset & res_valid & res_is_branch;
  assign rs_hit  = valid_q[rs_idx] & (tag_q[rs_idx] == rs_tag);

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // Fetch-side lookup on pre-edge table contents; forced to a miss in reset.
  always_comb begin
    pred_hit     = 1'b0;
    pred_taken   = 1'b0;
    pred_next_pc = pc_current + PC_ONE;
    if (reset && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
      pred_hit   = 1'b1;
      pred_taken = ctr_q[lk_idx][CTR_W-1];
      if (ctr_q[lk_idx][CTR_W-1]) begin
        pred_next_pc = target_q[lk_idx];
      end else begin
        pred_next_pc = pc_current + PC_ONE;
      end
    end else begin
      pred_hit   = 1'b0;
      pred_taken = 1'b0;
    end
  end

  // Same-cycle mispredict redirect from the resolving branch.
  always_comb begin
    change_pc = res_evt & (res_taken != res_pred_taken);
    if (res_taken) begin
      next_pc = res_target;
    end else begin
      next_pc = res_pc_plus;
    end
  end

  // Next-state for the table: clear beats resolve; a not-taken miss leaves it alone.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (tbl_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (res_evt) begin
      if (rs_hit) begin
        if (res_taken) begin
          target_d[rs_idx] = res_target;
          if (ctr_q[rs_idx] != CTR_MAX) begin
            ctr_d[rs_idx] = ctr_q[rs_idx] + CTR_ONE;
          end else begin
            ctr_d[rs_idx] = ctr_q[rs_idx];
          end
        end else begin
          if (ctr_q[rs_idx] != CTR_MIN) begin
            ctr_d[rs_idx] = ctr_q[rs_idx] - CTR_ONE;
          end else begin
            ctr_d[rs_idx] = ctr_q[rs_idx];
          end
        end
      end else if (res_taken) begin
        valid_d[rs_idx]  = 1'b1;
        tag_d[rs_idx]    = rs_tag;
        target_d[rs_idx] = res_target;
        ctr_d[rs_idx]    = CTR_WT;
      end else begin
        valid_d[rs_idx] = valid_q[rs_idx];
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Next-state for the saturating statistics counters.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res_evt && (branch_cnt_q != STAT_MAX)) begin
      branch_cnt_d = branch_cnt_q + STAT_ONE;
    end else begin
      branch_cnt_d = branch_cnt_q;
    end
    if (change_pc && (mispred_cnt_q != STAT_MAX)) begin
      mispred_cnt_d = mispred_cnt_q + STAT_ONE;
    end else begin
      mispred_cnt_d = mispred_cnt_q;
    end
  end

  // State registers; reset discards any update presented on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= {TAG_W{1'b0}};
        target_q[i] <= {PC_W{1'b0}};
        ctr_q[i]    <= CTR_WNT;
      end
      branch_cnt_q  <= {STAT_W{1'b0}};
      mispred_cnt_q <= {STAT_W{1'b0}};
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht (PC_W=16, ENTRIES=16, CTR_W=2, STAT_W=4).
module tb_branch_predictor_bht;

  logic        clk;
  logic        reset;
  logic [15:0] pc_current;
  logic        pred_hit;
  logic        pred_taken;
  logic [15:0] pred_next_pc;
  logic        res_valid;
  logic        res_is_branch;
  logic [15:0] res_pc;
  logic [15:0] res_pc_plus;
  logic [15:0] res_target;
  logic        res_taken;
  logic        res_pred_taken;
  logic        tbl_clear;
  logic        change_pc;
  logic [15:0] next_pc;
  logic [3:0]  branch_cnt;
  logic [3:0]  mispred_cnt;

  int n_checks;
  int n_fail;

  branch_predictor_bht #(
    .PC_W(16), .ENTRIES(16), .CTR_W(2), .STAT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .pc_current(pc_current),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_pc(res_pc),
    .res_pc_plus(res_pc_plus), .res_target(res_target), .res_taken(res_taken),
    .res_pred_taken(res_pred_taken), .tbl_clear(tbl_clear),
    .change_pc(change_pc), .next_pc(next_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs then change 1 unit after it, checks precede the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic v, input logic br, input logic [15:0] pc,
                           input logic [15:0] tgt, input logic tk, input logic pt);
    res_valid      = v;
    res_is_branch  = br;
    res_pc         = pc;
    res_pc_plus    = pc + 16'd1;
    res_target     = tgt;
    res_taken      = tk;
    res_pred_taken = pt;
  endtask

  task automatic idle();
    drive_res(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic look(input string tag, input logic [15:0] pc, input logic hit,
                      input logic tk, input logic [15:0] npc);
    pc_current = pc;
    #1;
    check_eq({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
    check_eq({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
    check_eq({tag, "_npc"}, {16'd0, pred_next_pc}, {16'd0, npc});
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    tbl_clear  = 1'b0;
    pc_current = 16'h0010;
    idle();
    tick();
    tick();

    // Reset held: lookup misses, branch resolve cannot redirect, stats zero.
    drive_res(1'b1, 1'b1, 16'h0010, 16'h0030, 1'b0, 1'b1);
    look("rst_look", 16'h0010, 1'b0, 1'b0, 16'h0011);
    check_eq("rst_chg", {31'd0, change_pc}, 32'd0);
    check_eq("rst_bcnt", {28'd0, branch_cnt}, 32'd0);
    check_eq("rst_mcnt", {28'd0, mispred_cnt}, 32'd0);
    idle();
    tick();
    reset = 1'b1;

    // Test 1: miss after reset; non-branch with pred_taken=1 never redirects.
    look("t1_look", 16'h0010, 1'b0, 1'b0, 16'h0011);
    drive_res(1'b1, 1'b0, 16'h0010, 16'h0030, 1'b0, 1'b1);
    #1;
    check_eq("t1_chg", {31'd0, change_pc}, 32'd0);
    tick();
    check_eq("t1_bcnt", {28'd0, branch_cnt}, 32'd0);

    // Test 2: taken miss allocates and redirects; same-cycle lookup still misses.
    drive_res(1'b1, 1'b1, 16'h0010, 16'h0030, 1'b1, 1'b0);
    look("t2_same", 16'h0010, 1'b0, 1'b0, 16'h0011);
    check_eq("t2_chg", {31'd0, change_pc}, 32'd1);
    check_eq("t2_npc", {16'd0, next_pc}, 32'h0030);
    tick();
    idle();
    look("t2_after", 16'h0010, 1'b1, 1'b1, 16'h0030);
    check_eq("t2_bcnt", {28'd0, branch_cnt}, 32'd1);
    check_eq("t2_mcnt", {28'd0, mispred_cnt}, 32'd1);

    // Test 3: ctr 10 -> 01 -> 00 -> 00 (no wrap below zero).
    drive_res(1'b1, 1'b1, 16'h0010, 16'h0030, 1'b0, 1'b1);
    #1;
    check_eq("t3_chg1", {31'd0, change_pc}, 32'd1);
    check_eq("t3_npc1", {16'd0, next_pc}, 32'h0011);
    tick();
    look("t3_c01", 16'h0010, 1'b1, 1'b0, 16'h0011);
    drive_res(1'b1, 1'b1, 16'h0010, 16'h0030, 1'b0, 1'b0);
    #1;
    check_eq("t3_chg2", {31'd0, change_pc}, 32'd0);
    tick();
    tick();
    idle();
    look("t3_c00", 16'h0010, 1'b1, 1'b0, 16'h0011);
    // Two takens from 00: 01 (still not taken), then 10 (taken).
    drive_res(1'b1, 1'b1, 16'h0010, 16'h0030, 1'b1, 1'b0);
    tick();
    idle();
    look("t3_up01", 16'h0010, 1'b1, 1'b0, 16'h0011);
    drive_res(1'b1, 1'b1, 16'h0010, 16'h0030, 1'b1, 1'b0);
    tick();
    idle();
    look("t3_up10", 16'h0010, 1'b1, 1'b1, 16'h0030);
    // Two more takens: 11, then saturate at 11; target rewritten to 0x0031.
    drive_res(1'b1, 1'b1, 16'h0010, 16'h0030, 1'b1, 1'b1);
    tick();
    drive_res(1'b1, 1'b1, 16'h0010, 16'h0031, 1'b1, 1'b1);
    tick();
    idle();
    look("t3_sat11", 16'h0010, 1'b1, 1'b1, 16'h0031);
    // One not-taken from 11 lands on 10, still predicted taken.
    drive_res(1'b1, 1'b1, 16'h0010, 16'h0031, 1'b0, 1'b1);
    tick();
    idle();
    look("t3_dn10", 16'h0010, 1'b1, 1'b1, 16'h0031);
    check_eq("t3_bcnt", {28'd0, branch_cnt}, 32'd9);
    check_eq("t3_mcnt", {28'd0, mispred_cnt}, 32'd5);

    // Test 4: aliasing on index 0 replaces 0x0010 with 0x0020.
    drive_res(1'b1, 1'b1, 16'h0020, 16'h0040, 1'b1, 1'b0);
    #1;
    check_eq("t4_chg", {31'd0, change_pc}, 32'd1);
    check_eq("t4_npc", {16'd0, next_pc}, 32'h0040);
    tick();
    idle();
    look("t4_old", 16'h0010, 1'b0, 1'b0, 16'h0011);
    look("t4_new", 16'h0020, 1'b1, 1'b1, 16'h0040);
    // Not-taken miss leaves the table unchanged.
    drive_res(1'b1, 1'b1, 16'h0035, 16'h0099, 1'b0, 1'b0);
    tick();
    idle();
    look("t4_ntmiss", 16'h0035, 1'b0, 1'b0, 16'h0036);

    // Test 5: lookup during a same-index resolve sees the old entry.
    drive_res(1'b1, 1'b1, 16'h0020, 16'h0040, 1'b0, 1'b1);
    look("t5_same", 16'h0020, 1'b1, 1'b1, 16'h0040);
    tick();
    idle();
    look("t5_next", 16'h0020, 1'b1, 1'b0, 16'h0021);
    // Clear beats a same-cycle taken resolve, which is still counted.
    tbl_clear = 1'b1;
    drive_res(1'b1, 1'b1, 16'h0050, 16'h0060, 1'b1, 1'b0);
    tick();
    tbl_clear = 1'b0;
    idle();
    look("t5_clr50", 16'h0050, 1'b0, 1'b0, 16'h0051);
    look("t5_clr20", 16'h0020, 1'b0, 1'b0, 16'h0021);
    check_eq("t5_bcnt", {28'd0, branch_cnt}, 32'd13);
    check_eq("t5_mcnt", {28'd0, mispred_cnt}, 32'd8);

    // Branch counter saturates at 0xF (STAT_W=4) after five more branches.
    drive_res(1'b1, 1'b1, 16'h0077, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    idle();
    check_eq("sat_bcnt", {28'd0, branch_cnt}, 32'd15);
    check_eq("sat_mcnt", {28'd0, mispred_cnt}, 32'd8);

    // Fetch PC increment wraps at the top of the address space.
    look("wrap", 16'hFFFF, 1'b0, 1'b0, 16'h0000);

    // Test 6: allocate two entries, then reset with a resolve in flight.
    drive_res(1'b1, 1'b1, 16'h0010, 16'h0030, 1'b1, 1'b0);
    tick();
    drive_res(1'b1, 1'b1, 16'h0023, 16'h0044, 1'b1, 1'b0);
    tick();
    idle();
    look("t6_pre", 16'h0023, 1'b1, 1'b1, 16'h0044);
    reset = 1'b0;
    drive_res(1'b1, 1'b1, 16'h0027, 16'h0050, 1'b1, 1'b0);
    look("t6_inrst", 16'h0010, 1'b0, 1'b0, 16'h0011);
    check_eq("t6_chg", {31'd0, change_pc}, 32'd0);
    tick();
    idle();
    reset = 1'b1;
    check_eq("t6_bcnt", {28'd0, branch_cnt}, 32'd0);
    check_eq("t6_mcnt", {28'd0, mispred_cnt}, 32'd0);
    look("t6_l10", 16'h0010, 1'b0, 1'b0, 16'h0011);
    look("t6_l23", 16'h0023, 1'b0, 1'b0, 16'h0024);
    look("t6_l27", 16'h0027, 1'b0, 1'b0, 16'h0028);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
